// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a WIDTH-bit word on valid/ready and shifts it out MSB-first.
// Define PARITY_EN to append one even-parity bit after each word.
module seq_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int MAXC = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] G_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

`ifdef PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2, S_PAR = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_e;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               word_done_q, word_done_d;
  logic               data_ready_q, data_ready_d;
`ifdef PARITY_EN
  logic               par_q, par_d;
`endif
  logic               accept;

  // A word can only be accepted in IDLE or, with GAP=0, on the final bit of the previous word.
  assign accept = data_valid && data_ready_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      // NOTE: the shift register is an ordinary flop bank, so it is cleared with everything else.
      shreg_q      <= '0;
      cnt_q        <= '0;
      out_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
      data_ready_q <= 1'b0;
`ifdef PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      word_done_q  <= word_done_d;
      data_ready_q <= data_ready_d;
`ifdef PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_SHIFT: begin
        if (cnt_q != W_LAST) begin
          cnt_d   = cnt_q + 1'b1;
          shreg_d = shreg_q << 1;
        end else begin
`ifdef PARITY_EN
          state_d = S_PAR;
`else
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
          cnt_d   = '0;
`endif
        end
      end
`ifdef PARITY_EN
      S_PAR: begin
        state_d = (GAP > 0) ? S_GAP : S_IDLE;
        cnt_d   = '0;
      end
`endif
      S_GAP: begin
        if (cnt_q == G_LAST) state_d = S_IDLE;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Accepting a word overrides whatever the current word would have done next.
    if (accept) begin
      state_d = S_SHIFT;
      shreg_d = data_in;
      cnt_d   = '0;
`ifdef PARITY_EN
      par_d   = ^data_in;
`endif
    end
  end

  // Outputs are decoded from the next state and registered, so each appears the cycle the state is entered.
  always_comb begin
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    word_done_d = 1'b0;
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_SHIFT: begin
        out_d       = shreg_d[WIDTH-1];
        out_valid_d = 1'b1;
`ifndef PARITY_EN
        word_done_d = (cnt_d == W_LAST);
`endif
      end
`ifdef PARITY_EN
      S_PAR: begin
        out_d       = par_d;
        out_valid_d = 1'b1;
        word_done_d = 1'b1;
      end
`endif
      default: ;
    endcase
    data_ready_d = (state_d == S_IDLE) || ((GAP == 0) && word_done_d);
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign word_done  = word_done_q;
  assign data_ready = data_ready_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: one instance with GAP=1, one with GAP=0 (back-to-back).
module tb_seq_pattern_tx;

  localparam int W = 4;
`ifdef PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int WL = W + int'(PAR_EN);
  localparam int NV = 7;

  typedef struct { logic [W-1:0] word; logic [W-1:0] exp_bits; logic exp_par; } vec_t;
  typedef struct { logic b; logic done; } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] d1_in, d0_in;
  logic d1_valid, d0_valid;
  logic d1_ready, o1, v1, b1, wd1;
  logic d0_ready, o0, v0, b0, wd0;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q1[$];
  exp_t q0[$];
  exp_t e1, e0;
  int run0 = 0;
  int max0 = 0;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(W), .GAP(1)) u_g1 (
    .clk(clk), .rst(rst), .data_in(d1_in), .data_valid(d1_valid), .data_ready(d1_ready),
    .out(o1), .out_valid(v1), .busy(b1), .word_done(wd1));

  seq_pattern_tx #(.WIDTH(W), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .data_in(d0_in), .data_valid(d0_valid), .data_ready(d0_ready),
    .out(o0), .out_valid(v0), .busy(b0), .word_done(wd0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected serial bits of one word; nbits < WL models a word cut short by reset.
  task automatic push_word(input bit sel, input logic [W-1:0] bits, input logic par, input int nbits);
    exp_t e;
    for (int k = 0; k < W; k++) begin
      if (k < nbits) begin
        e.b    = bits[W-1-k];
        e.done = !PAR_EN && (k == W - 1);
        if (sel) q0.push_back(e); else q1.push_back(e);
      end
    end
    if (PAR_EN && nbits > W) begin
      e.b    = par;
      e.done = 1'b1;
      if (sel) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic wait_ready(input bit sel, input string name);
    int n = 0;
    while (((sel ? d0_ready : d1_ready) !== 1'b1) && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 64) check(name, sel ? d0_ready : d1_ready, 1);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q0.size() != 0 || b1 || b0) && n < 64) begin
      step();
      n++;
    end
    step();
    check("drain_q1", q1.size(), 0);
    check("drain_q0", q0.size(), 0);
  endtask

  // Scoreboard monitors sample away from the active edge.
  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) check("g1_unexpected_valid", v1, 0);
      else begin
        e1 = q1.pop_front();
        check("g1_bit", o1, e1.b);
        check("g1_word_done", wd1, e1.done);
      end
    end else begin
      check("g1_idle_out", o1, 0);
      check("g1_idle_word_done", wd1, 0);
    end
  end

  always @(negedge clk) begin
    if (v0) begin
      run0++;
      if (run0 > max0) max0 = run0;
      if (q0.size() == 0) check("g0_unexpected_valid", v0, 0);
      else begin
        e0 = q0.pop_front();
        check("g0_bit", o0, e0.b);
        check("g0_word_done", wd0, e0.done);
      end
    end else begin
      run0 = 0;
      check("g0_idle_out", o0, 0);
      check("g0_idle_word_done", wd0, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] tw;
    logic tp;

    vecs[0] = '{word: 4'b1101, exp_bits: 4'b1101, exp_par: 1'b1};
    vecs[1] = '{word: 4'b1011, exp_bits: 4'b1011, exp_par: 1'b1};
    vecs[2] = '{word: 4'b0000, exp_bits: 4'b0000, exp_par: 1'b0};
    vecs[3] = '{word: 4'b1111, exp_bits: 4'b1111, exp_par: 1'b0};
    vecs[4] = '{word: 4'b1000, exp_bits: 4'b1000, exp_par: 1'b1};
    vecs[5] = '{word: 4'b0110, exp_bits: 4'b0110, exp_par: 1'b0};
    vecs[6] = '{word: 4'b0001, exp_bits: 4'b0001, exp_par: 1'b1};

    rst = 1'b1; d1_in = '0; d0_in = '0; d1_valid = 1'b0; d0_valid = 1'b0;

    // Reset held for two cycles, then ready one cycle after release.
    step(); step();
    check("rst_out", o1, 0);
    check("rst_out_valid", v1, 0);
    check("rst_ready", d1_ready, 0);
    check("rst_busy", b1, 0);
    check("rst_word_done", wd1, 0);
    check("rst_ready_g0", d0_ready, 0);
    rst = 1'b0;
    check("ready_low_before_edge", d1_ready, 0);
    step();
    check("ready_after_release", d1_ready, 1);
    check("ready_after_release_g0", d0_ready, 1);

    // Cycle-exact timing of 4'b1101 with GAP=1.
    tw = 4'b1101; tp = 1'b1;
    d1_in = tw; d1_valid = 1'b1;
    push_word(0, tw, tp, WL);
    step();
    d1_valid = 1'b0;
    for (int c = 1; c <= WL + 2; c++) begin
      if (c <= WL) begin
        check("t_out", o1, (c <= W) ? tw[W-c] : tp);
        check("t_out_valid", v1, 1);
        check("t_word_done", wd1, c == WL);
        check("t_busy", b1, 1);
        check("t_ready", d1_ready, 0);
      end else if (c == WL + 1) begin
        check("t_gap_out", o1, 0);
        check("t_gap_valid", v1, 0);
        check("t_gap_busy", b1, 1);
        check("t_gap_ready", d1_ready, 0);
      end else begin
        check("t_idle_ready", d1_ready, 1);
        check("t_idle_busy", b1, 0);
      end
      step();
    end
    drain();

    // Table: each vector sent alone on the GAP=1 instance.
    for (int i = 0; i < NV; i++) begin
      d1_in = vecs[i].word; d1_valid = 1'b1;
      wait_ready(0, "tbl_g1_ready_timeout");
      push_word(0, vecs[i].exp_bits, vecs[i].exp_par, WL);
      step();
      d1_valid = 1'b0;
    end
    drain();

    // Table: all vectors streamed back-to-back on the GAP=0 instance.
    max0 = 0;
    d0_valid = 1'b1;
    for (int i = 0; i < NV; i++) begin
      d0_in = vecs[i].word;
      wait_ready(1, "tbl_g0_ready_timeout");
      push_word(1, vecs[i].exp_bits, vecs[i].exp_par, WL);
      step();
    end
    d0_valid = 1'b0;
    drain();
    check("g0_contiguous_bits", max0, NV * WL);

    // data_in changing mid-word must not disturb the word in flight.
    d1_in = 4'b1101; d1_valid = 1'b1;
    wait_ready(0, "mid_ready_timeout");
    push_word(0, 4'b1101, 1'b1, WL);
    step();
    d1_in = 4'b0000;
    check("mid_ready_low", d1_ready, 0);
    wait_ready(0, "mid_ready2_timeout");
    push_word(0, 4'b0000, 1'b0, WL);
    step();
    d1_valid = 1'b0;
    drain();

    // Reset during bit 2 of 4'b1111 aborts the word.
    d1_in = 4'b1111; d1_valid = 1'b1;
    wait_ready(0, "abort_ready_timeout");
    push_word(0, 4'b1111, 1'b0, 2);
    step();
    d1_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("abort_out", o1, 0);
    check("abort_out_valid", v1, 0);
    check("abort_busy", b1, 0);
    check("abort_word_done", wd1, 0);
    check("abort_queue", q1.size(), 0);
    rst = 1'b0;
    check("abort_ready_in_reset", d1_ready, 0);
    step();
    check("abort_ready_after", d1_ready, 1);
    repeat (8) step();
    check("abort_no_more_bits", q1.size(), 0);

    // Reset coinciding with an accept: the word is never sent.
    d1_in = 4'b1011; d1_valid = 1'b1; rst = 1'b1;
    step();
    d1_valid = 1'b0; rst = 1'b0;
    check("rst_acc_valid", v1, 0);
    check("rst_acc_busy", b1, 0);
    check("rst_acc_ready", d1_ready, 0);
    repeat (8) step();
    check("rst_acc_busy_later", b1, 0);
    check("rst_acc_ready_later", d1_ready, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
